// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined main memory between the I-cache and D-cache, routing read returns to the issuer.
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner of simultaneous IDLE requests.
module cache_mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_MemRead,
    input  logic [ADDR_W-1:0] icache_mem_addr,
    output logic              icache_grant,
    output logic              icache_MemDataValid,
    output logic [DATA_W-1:0] icache_mem_read_data,
    input  logic              dcache_MemRead,
    input  logic              dcache_MemWrite,
    input  logic [ADDR_W-1:0] dcache_mem_addr,
    input  logic [DATA_W-1:0] dcache_mem_write_data,
    output logic              dcache_grant,
    output logic              dcache_MemDataValid,
    output logic [DATA_W-1:0] dcache_mem_read_data,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, I_GRANT, D_GRANT, DRAIN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t           state_reg, state_next;
    owner_t           owner_reg, owner_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    owner_t           cur_owner, tie_winner;
    logic             d_req, i_req, owner_req, full, issue, read_issue, ret_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_i_reg, last_i_next;
    assign tie_winner  = last_i_reg ? OWN_D : OWN_I;
    assign last_i_next = (state_reg == IDLE && cur_owner != OWN_NONE) ? (cur_owner == OWN_I) : last_i_reg;
`else
    assign tie_winner = OWN_D;
`endif

    assign d_req = dcache_MemRead | dcache_MemWrite;
    assign i_req = icache_MemRead;
    assign full  = (cnt_reg == CNT_FULL);

    // In IDLE the arbitration winner is treated as owner in the same cycle (zero-latency grant).
    always_comb begin
        cur_owner = OWN_NONE;
        unique case (state_reg)
            IDLE: begin
                if (d_req && i_req) cur_owner = tie_winner;
                else if (d_req)     cur_owner = OWN_D;
                else if (i_req)     cur_owner = OWN_I;
            end
            I_GRANT: cur_owner = OWN_I;
            D_GRANT: cur_owner = OWN_D;
            default: cur_owner = OWN_NONE;
        endcase
    end

    assign owner_req  = (cur_owner == OWN_D) ? d_req : ((cur_owner == OWN_I) ? i_req : 1'b0);
    assign issue      = owner_req & ~full & ~rst;
    assign read_issue = issue & ~mem_wr;

    assign icache_grant = issue & (cur_owner == OWN_I);
    assign dcache_grant = issue & (cur_owner == OWN_D);
    assign mem_enable   = issue;
    assign mem_wr       = dcache_grant & dcache_MemWrite;
    assign mem_addr     = dcache_grant ? dcache_mem_addr : (icache_grant ? icache_mem_addr : '0);
    assign mem_data_in  = dcache_grant ? dcache_mem_write_data : '0;

    // Returns with nothing outstanding (stale after reset, or spurious) are dropped.
    assign ret_valid            = mem_data_valid & (cnt_reg != '0) & ~rst;
    assign icache_MemDataValid  = ret_valid & (owner_reg == OWN_I);
    assign dcache_MemDataValid  = ret_valid & (owner_reg == OWN_D);
    assign icache_mem_read_data = mem_data_out;
    assign dcache_mem_read_data = mem_data_out;

    always_comb begin
        cnt_next = cnt_reg;
        if (read_issue && !ret_valid)      cnt_next = cnt_reg + CNT_W'(1);
        else if (!read_issue && ret_valid) cnt_next = cnt_reg - CNT_W'(1);
    end

    // Release decisions use the post-update count so a return landing in the release cycle is not missed.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        unique case (state_reg)
            IDLE: begin
                if (cur_owner != OWN_NONE) begin
                    state_next = (cur_owner == OWN_I) ? I_GRANT : D_GRANT;
                    owner_next = cur_owner;
                end
            end
            I_GRANT, D_GRANT: begin
                if (!owner_req) begin
                    if (cnt_next == '0) begin
                        state_next = IDLE;
                        owner_next = OWN_NONE;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            default: begin
                if (cnt_next == '0) begin
                    state_next = IDLE;
                    owner_next = OWN_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            owner_reg  <= OWN_NONE;
            cnt_reg    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_i_reg <= 1'b1;
`endif
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
`ifdef ARB_ROUND_ROBIN_EN
            last_i_reg <= last_i_next;
`endif
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter: per-cycle command check against a reference model,
// plus a return scoreboard consumed by an independent monitor.
module tb_cache_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_MemRead;
    logic [15:0] icache_mem_addr;
    logic        icache_grant, icache_MemDataValid;
    logic [15:0] icache_mem_read_data;
    logic        dcache_MemRead, dcache_MemWrite;
    logic [15:0] dcache_mem_addr, dcache_mem_write_data;
    logic        dcache_grant, dcache_MemDataValid;
    logic [15:0] dcache_mem_read_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_data_valid;
    logic [15:0] mem_data_out;

    cache_mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .icache_MemRead(icache_MemRead), .icache_mem_addr(icache_mem_addr),
        .icache_grant(icache_grant), .icache_MemDataValid(icache_MemDataValid),
        .icache_mem_read_data(icache_mem_read_data),
        .dcache_MemRead(dcache_MemRead), .dcache_MemWrite(dcache_MemWrite),
        .dcache_mem_addr(dcache_mem_addr), .dcache_mem_write_data(dcache_mem_write_data),
        .dcache_grant(dcache_grant), .dcache_MemDataValid(dcache_MemDataValid),
        .dcache_mem_read_data(dcache_mem_read_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  who;   // 1 = I-cache, 2 = D-cache
        logic [15:0] data;
    } ret_t;

    ret_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_n = 0;

    // Reference model state: who owns memory, whether it is draining, reads in flight.
    int          m_state = 0;   // 0 idle, 1 I owns, 2 D owns, 3 draining
    int          m_own = 0;     // owner used for routing returns
    int          m_cnt = 0;
    bit          m_last_i = 1'b1;
    logic [15:0] seq = 16'd1;

    // Memory model: fixed-latency pipeline fed by the model's read issues.
    logic        issued_rec = 1'b0;
    logic [15:0] issued_data = 16'd0;
    logic        spur_req = 1'b0;
    logic        pv[4];
    logic [15:0] pd[4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            pv[k] = 1'b0;
            pd[k] = 16'd0;
        end
        mem_data_valid = 1'b0;
        mem_data_out   = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 3; k > 0; k--) begin
                pv[k] = pv[k-1];
                pd[k] = pd[k-1];
            end
            pv[0] = issued_rec;
            pd[0] = issued_data;
            if (spur_req) begin
                mem_data_valid = 1'b1;
                mem_data_out   = 16'($urandom);
                spur_req       = 1'b0;
            end else begin
                mem_data_valid = pv[3];
                mem_data_out   = pv[3] ? pd[3] : 16'($urandom);
            end
        end
    end

    task automatic model_step();
        logic [37:0] exp_v, got_v;
        logic        d_req, i_req, req_now, issue, wr, rv;
        logic [15:0] addr, din;
        int          own_now, cnt_nx;
        if (rst) begin
            exp_v      = '0;
            m_state    = 0;
            m_own      = 0;
            m_cnt      = 0;
            m_last_i   = 1'b1;
            issued_rec = 1'b0;
            sb.delete();
        end else begin
            d_req   = dcache_MemRead | dcache_MemWrite;
            i_req   = icache_MemRead;
            own_now = 0;
            case (m_state)
                0: begin
                    if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        own_now = m_last_i ? 2 : 1;
`else
                        own_now = 2;
`endif
                    end else if (d_req) own_now = 2;
                    else if (i_req)     own_now = 1;
                end
                1: own_now = 1;
                2: own_now = 2;
                default: own_now = 0;
            endcase
            req_now = (own_now == 2) ? d_req : ((own_now == 1) ? i_req : 1'b0);
            issue   = req_now && (m_cnt < LAT);
            wr      = issue && (own_now == 2) && dcache_MemWrite;
            rv      = mem_data_valid && (m_cnt > 0);
            addr    = !issue ? 16'd0 : ((own_now == 2) ? dcache_mem_addr : icache_mem_addr);
            din     = (issue && own_now == 2) ? dcache_mem_write_data : 16'd0;
            exp_v   = {issue && own_now == 1, issue && own_now == 2, issue, wr, addr, din,
                       rv && m_own == 1, rv && m_own == 2};
            if (issue && !wr) begin
                sb.push_back({2'(own_now), seq});
                issued_rec  = 1'b1;
                issued_data = seq;
                seq         = seq + 16'd1;
            end else begin
                issued_rec = 1'b0;
            end
            cnt_nx = m_cnt + ((issue && !wr) ? 1 : 0) - (rv ? 1 : 0);
            case (m_state)
                0: if (own_now != 0) begin
                    m_state  = own_now;
                    m_own    = own_now;
                    m_last_i = (own_now == 1);
                end
                1, 2: if (!req_now) begin
                    if (cnt_nx == 0) begin
                        m_state = 0;
                        m_own   = 0;
                    end else begin
                        m_state = 3;
                    end
                end
                default: if (cnt_nx == 0) begin
                    m_state = 0;
                    m_own   = 0;
                end
            endcase
            m_cnt = cnt_nx;
        end
        got_v = {icache_grant, dcache_grant, mem_enable, mem_wr, mem_addr, mem_data_in,
                 icache_MemDataValid, dcache_MemDataValid};
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL cmd cycle %0d: got {ig,dg,en,wr,addr,din,iv,dv}=%h, required %h", cyc_n, got_v, exp_v);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            model_step();
        end
    end

    // Return monitor: every routed word must match the oldest outstanding expectation.
    initial begin
        ret_t        e;
        logic [17:0] got_r, exp_r;
        forever begin
            @(negedge clk);
            if (icache_MemDataValid || dcache_MemDataValid) begin
                vectors++;
                got_r = {icache_MemDataValid, dcache_MemDataValid,
                         icache_MemDataValid ? icache_mem_read_data : dcache_mem_read_data};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL ret cycle %0d: got {iv,dv,data}=%h, required no return", cyc_n, got_r);
                end else begin
                    e     = sb.pop_front();
                    exp_r = {e.who == 2'd1, e.who == 2'd2, e.data};
                    if (got_r !== exp_r) begin
                        miscompares++;
                        $display("FAIL ret cycle %0d: got {iv,dv,data}=%h, required %h", cyc_n, got_r, exp_r);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input bit d_side);
        int t = 0;
        bit got = 1'b0;
        while (!got && t <= 200) begin
            @(negedge clk);
            got = d_side ? dcache_grant : icache_grant;
            t++;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout %s: got no grant, required grant within 200 cycles", d_side ? "dcache" : "icache");
        end
    endtask

    task automatic d_burst(input int n, input logic [1:0] mode, input logic [15:0] base, input logic [15:0] wdata);
        for (int k = 0; k < n; k++) begin
            dcache_MemRead        = mode[0];
            dcache_MemWrite       = mode[1];
            dcache_mem_addr       = base + 16'(2 * k);
            dcache_mem_write_data = wdata + 16'(k);
            wait_grant(1'b1);
            @(posedge clk);
            #1;
        end
        dcache_MemRead  = 1'b0;
        dcache_MemWrite = 1'b0;
    endtask

    task automatic i_burst(input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            icache_MemRead  = 1'b1;
            icache_mem_addr = base + 16'(2 * k);
            wait_grant(1'b0);
            @(posedge clk);
            #1;
        end
        icache_MemRead = 1'b0;
    endtask

    task automatic reset_mid_fill();
        idle(8);
        dcache_MemRead  = 1'b1;
        dcache_mem_addr = 16'h0100;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            dcache_mem_addr = dcache_mem_addr + 16'd2;
        end
        rst            = 1'b1;
        dcache_MemRead = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(6);
    endtask

    task automatic spurious();
        idle(8);
        @(negedge clk);
        spur_req = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int r;
        rst                   = 1'b1;
        icache_MemRead        = 1'b0;
        icache_mem_addr       = 16'd0;
        dcache_MemRead        = 1'b0;
        dcache_MemWrite       = 1'b0;
        dcache_mem_addr       = 16'd0;
        dcache_mem_write_data = 16'd0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Two back-to-back ties: D wins first; second tie depends on the arbitration build.
        for (int t = 0; t < 2; t++) begin
            fork
                d_burst(3, 2'b01, 16'h0010, 16'd0);
                i_burst(3, 16'h0008);
            join
            idle(8);
        end
        d_burst(8, 2'b01, 16'h0004, 16'd0);
        idle(8);
        d_burst(1, 2'b10, 16'h0020, 16'hBEEF);
        idle(3);
        d_burst(2, 2'b11, 16'h0030, 16'h1234);
        idle(4);
        i_burst(2, 16'h0040);
        d_burst(2, 2'b01, 16'h0050, 16'd0);
        reset_mid_fill();
        spurious();

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: d_burst($urandom_range(1, 8), 2'b01, 16'($urandom) & 16'hFFFE, 16'd0);
                2:    d_burst($urandom_range(1, 3), 2'($urandom_range(2, 3)), 16'($urandom) & 16'hFFFE, 16'($urandom));
                3, 4: i_burst($urandom_range(1, 8), 16'($urandom) & 16'hFFFE);
                5, 6: fork
                          d_burst($urandom_range(1, 6), 2'($urandom_range(1, 3)), 16'($urandom) & 16'hFFFE, 16'($urandom));
                          i_burst($urandom_range(1, 6), 16'($urandom) & 16'hFFFE);
                      join
                7:    idle($urandom_range(0, 6));
                8:    spurious();
                default: begin
                    if ($urandom_range(0, 3) == 0) reset_mid_fill();
                    else idle(1);
                end
            endcase
        end

        idle(12);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d returns still outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the I-cache and D-cache controllers and the single shared multi-cycle main memory.
- Grants memory to one cache at a time and holds the grant for that cache's whole miss-fill or write burst.
- Forwards the owner's read/write commands to memory.
- Tracks outstanding pipelined reads and routes each returned word to the cache that issued it.

Parameters:
- MEM_LATENCY, 4: cycles from a read issue to its mem_data_valid; also the maximum number of reads in flight.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- icache_MemRead  in  1  I-cache requests a memory read.
- icache_mem_addr  in  ADDR_W  I-cache read address.
- icache_grant  out  1  I-cache owns memory this cycle; its command is forwarded.
- icache_MemDataValid  out  1  returned word belongs to I-cache.
- icache_mem_read_data  out  DATA_W  returned word (qualified by icache_MemDataValid).
- dcache_MemRead  in  1  D-cache requests a memory read.
- dcache_MemWrite  in  1  D-cache requests a memory write.
- dcache_mem_addr  in  ADDR_W  D-cache address.
- dcache_mem_write_data  in  DATA_W  D-cache write data.
- dcache_grant  out  1  D-cache owns memory this cycle.
- dcache_MemDataValid  out  1  returned word belongs to D-cache.
- dcache_mem_read_data  out  DATA_W  returned word (qualified by dcache_MemDataValid).
- mem_enable  out  1  memory command valid.
- mem_wr  out  1  1 = write, 0 = read (meaningful only when mem_enable=1).
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.
- mem_data_valid  in  1  memory read data valid.
- mem_data_out  in  DATA_W  memory read data.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, outstanding count 0, owner NONE; both grants 0, both MemDataValid 0, mem_enable 0, mem_wr 0, mem_addr 0, mem_data_in 0.
- States:
  - IDLE: no owner.
  - I_GRANT: I-cache owns memory.
  - D_GRANT: D-cache owns memory.
  - DRAIN: owner retained, no new issues, waiting for in-flight reads.
- Request signals:
  - d_req = dcache_MemRead | dcache_MemWrite.
  - i_req = icache_MemRead.
- IDLE arbitration is combinational and zero-latency:
  - The winner's grant is asserted and its command drives memory in the same cycle.
  - Next state is the winner's GRANT state.
  - Fixed priority: D over I.
- Forwarding in the GRANT states:
  - mem_enable = owner's request.
  - mem_wr = dcache_MemWrite, D owner only; I owner always reads.
  - mem_addr and mem_data_in come from the owner.
  - If dcache_MemRead and dcache_MemWrite are both high, the write takes precedence.
- Non-owner is held off: its grant stays 0 and its command is not forwarded. It must hold its request until granted.
- Release: when the owner's request drops, that cycle issues nothing.
  - Outstanding count 0 -> IDLE next cycle.
  - Otherwise -> DRAIN.
- DRAIN:
  - Both grants 0, mem_enable 0.
  - When the last outstanding word returns (valid with count 1) -> IDLE next cycle.
  - A new arbitration may occur in that IDLE cycle.
- Outstanding counter, width clog2(MEM_LATENCY+1):
  - +1 per forwarded read, -1 per mem_data_valid, unchanged when both happen in the same cycle.
  - Writes are not counted.
  - While the count equals MEM_LATENCY, the owner's grant is deasserted (backpressure) until a word returns.
- Return routing:
  - mem_data_out drives both *_mem_read_data combinationally.
  - mem_data_valid is steered to the MemDataValid of the registered owner, including in DRAIN.
  - mem_data_valid with count 0 is dropped; neither MemDataValid asserts.
- Reset asserted mid-burst: everything returns to reset values the next cycle. Later returns from reads already in flight are dropped because the count is 0.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: a 1-bit last-owner register breaks ties in IDLE. The cache that did not win most recently wins a simultaneous request. The register resets to I, so D wins the first tie.
- ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority.
- Single-requester behaviour is identical in both builds.

Test Plan:
- D-cache fill: after reset, dcache_MemRead=1 with addrs 0x0004..0x0012 step 2.
  - dcache_grant=1 the same cycle; memory receives 8 reads, stalled whenever 4 are in flight.
  - Returns 1..8 appear on dcache_MemDataValid/data; icache_MemDataValid stays 0.
  - State goes to IDLE after the last return.
- Simultaneous requests: I read 0x0008 and D read 0x0010 asserted together from IDLE.
  - Fixed build: D granted; I granted only after D drops its request and drains.
  - ARB_ROUND_ROBIN_EN build: D wins the first tie, I wins the next tie.
- D write: dcache_MemWrite=1, addr 0x0020, data 0xBEEF.
  - Same cycle: mem_enable=1, mem_wr=1, mem_addr=0x0020, mem_data_in=0xBEEF.
  - Count stays 0; back to IDLE the next cycle.
- Drain routing: I issues 2 reads then drops its request, D requests immediately.
  - State is DRAIN; both returns go to icache_MemDataValid.
  - dcache_grant rises only in the cycle after the second return.
- Reset mid-fill: rst=1 with 3 reads outstanding.
  - All outputs and the count are 0 the next cycle.
  - A subsequent mem_data_valid produces no MemDataValid on either cache.
- Spurious valid: mem_data_valid=1 while IDLE with count 0 -> both MemDataValid stay 0 and the count stays 0.
